// File: rtl/adder_tree_pkg.sv
// -----------------------------------------------------------------------------
// adder_tree_pkg
// Shared definitions for the 3-level, 8-operand adder tree and its loader.
//   ADDER_WIDTH  - operand width in bits
//   N_OPERANDS   - operands per frame (2^3 for the 3-level tree)
//   TREE_LATENCY - cycles from operand presentation to the tree's registered sum
//   loader_state_t - loader FSM states
//   operand_t      - one tree operand
// -----------------------------------------------------------------------------
package adder_tree_pkg;

    localparam int ADDER_WIDTH  = 8;
    localparam int N_OPERANDS   = 8;
    localparam int TREE_LATENCY = 2;

    typedef enum logic {
        FILL  = 1'b0,
        ISSUE = 1'b1
    } loader_state_t;

    typedef logic [ADDER_WIDTH-1:0] operand_t;

endpackage

// File: rtl/valid_delay_line.sv
// -----------------------------------------------------------------------------
// valid_delay_line
// Fixed-depth shift register that carries a {valid, tag} word alongside a
// pipelined datapath so the qualifier lines up with the data it describes.
// Reset clears every stage, so no stale valid can emerge after reset.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset (clears all stages)
//   din  - word entering the line
//   dout - din delayed by DEPTH cycles
// -----------------------------------------------------------------------------
module valid_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_p [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_p[i] <= '0;
            end
        end else begin
            stage_p[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_p[i] <= stage_p[i-1];
            end
        end
    end

    assign dout = stage_p[DEPTH-1];

endmodule

// File: rtl/adder_tree_loader.sv
// -----------------------------------------------------------------------------
// adder_tree_loader
// Packs a serial valid/ready operand stream into N_OPERANDS-wide frames for the
// adder tree. Short frames (closed early by in_last) are zero-padded. A frame is
// presented on 'operands' for one frame_valid pulse and held until the next
// frame; a delay line matched to the tree latency marks the cycle in which the
// tree's sum belongs to that frame.
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   in_data      - operand
//   in_valid     - in_data is valid
//   in_last      - operand closes the frame early (qualified by in_valid)
//   in_ready     - loader accepts an operand this cycle (registered, state only)
//   operands     - packed frame, slot k at [k*W +: W]
//   frame_valid  - one-cycle pulse, operands holds a new frame
//   frame_tag    - sequence number of the frame on operands
//   sum_valid    - frame_valid delayed by TREE_LATENCY
//   sum_tag      - frame_tag delayed by TREE_LATENCY
// -----------------------------------------------------------------------------
module adder_tree_loader #(
    parameter int ADDER_WIDTH  = adder_tree_pkg::ADDER_WIDTH,
    parameter int N_OPERANDS   = adder_tree_pkg::N_OPERANDS,
    parameter int TREE_LATENCY = adder_tree_pkg::TREE_LATENCY,
    parameter int TAG_WIDTH    = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [ADDER_WIDTH-1:0]            in_data,
    input  logic                              in_valid,
    input  logic                              in_last,
    output logic                              in_ready,
    output logic [N_OPERANDS*ADDER_WIDTH-1:0] operands,
    output logic                              frame_valid,
    output logic [TAG_WIDTH-1:0]              frame_tag,
    output logic                              sum_valid,
    output logic [TAG_WIDTH-1:0]              sum_tag
);

    import adder_tree_pkg::*;

    localparam int               CNT_W     = (N_OPERANDS > 1) ? $clog2(N_OPERANDS) : 1;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(N_OPERANDS - 1);

    loader_state_t          state;
    logic [CNT_W-1:0]       cnt;
    logic [TAG_WIDTH-1:0]   tag_cnt;
    logic [ADDER_WIDTH-1:0] fill_buf [N_OPERANDS];
    logic                   frame_done;

    // Only meaningful on an accepted transfer: last slot reached or early close.
    assign frame_done = in_last || (cnt == LAST_SLOT);

    // Fill stage -> issue stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL;
            cnt         <= '0;
            tag_cnt     <= '0;
            in_ready    <= 1'b1;
            operands    <= '0;
            frame_valid <= 1'b0;
            frame_tag   <= '0;
            for (int k = 0; k < N_OPERANDS; k++) begin
                fill_buf[k] <= '0;
            end
        end else begin
            frame_valid <= 1'b0;
            case (state)
                FILL: begin
                    if (in_valid && in_ready) begin
                        // Write the current slot; on frame completion also clear
                        // every slot above it so a short frame is zero-padded
                        // without a separate clear cycle.
                        for (int k = 0; k < N_OPERANDS; k++) begin
                            if (CNT_W'(k) == cnt) begin
                                fill_buf[k] <= in_data;
                            end else if (frame_done && (CNT_W'(k) > cnt)) begin
                                fill_buf[k] <= '0;
                            end
                        end
                        if (frame_done) begin
                            state    <= ISSUE;
                            in_ready <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ISSUE: begin
                    for (int k = 0; k < N_OPERANDS; k++) begin
                        operands[k*ADDER_WIDTH +: ADDER_WIDTH] <= fill_buf[k];
                    end
                    frame_valid <= 1'b1;
                    frame_tag   <= tag_cnt;
                    tag_cnt     <= tag_cnt + TAG_WIDTH'(1);
                    cnt         <= '0;
                    state       <= FILL;
                    in_ready    <= 1'b1;
                end
            endcase
        end
    end

    // Issue stage -> tree output stage
    valid_delay_line #(
        .DEPTH (TREE_LATENCY),
        .WIDTH (TAG_WIDTH + 1)
    ) u_sum_delay (
        .clk  (clk),
        .rst  (rst),
        .din  ({frame_valid, frame_tag}),
        .dout ({sum_valid, sum_tag})
    );

endmodule

// File: tb/tb_adder_tree_loader.sv
module tb_adder_tree_loader;

    import adder_tree_pkg::*;

    localparam int W  = 8;
    localparam int N  = 8;
    localparam int L  = 2;
    localparam int TW = 4;

    logic           clk = 1'b0;
    logic           rst;
    operand_t       in_data;
    logic           in_valid;
    logic           in_last;
    logic           in_ready;
    logic [N*W-1:0] operands;
    logic           frame_valid;
    logic [TW-1:0]  frame_tag;
    logic           sum_valid;
    logic [TW-1:0]  sum_tag;

    always #5 clk = ~clk;

    adder_tree_loader #(
        .ADDER_WIDTH  (W),
        .N_OPERANDS   (N),
        .TREE_LATENCY (L),
        .TAG_WIDTH    (TW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .operands    (operands),
        .frame_valid (frame_valid),
        .frame_tag   (frame_tag),
        .sum_valid   (sum_valid),
        .sum_tag     (sum_tag)
    );

    // Edge counter: value seen between edges is the number of edges so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: frames as plain arrays with the cycle they must appear in.
    typedef struct {
        int             cyc;
        logic [N*W-1:0] ops;
        logic [TW-1:0]  tag;
        int             sum;
    } frame_t;

    typedef struct {
        int            cyc;
        logic [TW-1:0] tag;
    } sum_t;

    frame_t         fq[$];
    sum_t           sq[$];
    operand_t       cur[$];
    logic [TW-1:0]  next_tag;
    logic [N*W-1:0] exp_ops;
    logic [TW-1:0]  exp_ftag;
    int             n_cmp = 0;
    int             n_bad = 0;
    int             n_sv_seen = 0;
    bit             mon_en = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // An accepted operand; transfer edge is cyc+1, frame visible after edge cyc+2.
    function automatic void model_accept(input operand_t d, input bit last);
        frame_t f;
        cur.push_back(d);
        if (last || cur.size() == N) begin
            f.ops = '0;
            f.sum = 0;
            for (int k = 0; k < cur.size(); k++) begin
                f.ops[k*W +: W] = cur[k];
                f.sum += int'(cur[k]);
            end
            f.cyc    = cyc + 2;
            f.tag    = next_tag;
            next_tag = next_tag + 1'b1;
            fq.push_back(f);
            cur.delete();
        end
    endfunction

    always @(negedge clk) begin : monitor
        frame_t f;
        int     obs;
        bit     exp_fv;
        bit     exp_sv;
        if (mon_en) begin
            while (fq.size() > 0 && fq[0].cyc < cyc) void'(fq.pop_front());
            while (sq.size() > 0 && sq[0].cyc < cyc) void'(sq.pop_front());
            exp_fv = (fq.size() > 0 && fq[0].cyc == cyc);
            chk("in_ready", in_ready, !(fq.size() > 0 && fq[0].cyc == cyc + 1));
            chk("frame_valid", frame_valid, exp_fv);
            if (exp_fv) begin
                f        = fq.pop_front();
                exp_ops  = f.ops;
                exp_ftag = f.tag;
                obs = 0;
                for (int k = 0; k < N; k++) obs += int'(operands[k*W +: W]);
                chk("tree_sum", obs, f.sum);
                sq.push_back('{cyc: cyc + L, tag: f.tag});
            end
            chk("operands", operands, exp_ops);
            chk("frame_tag", frame_tag, exp_ftag);
            exp_sv = (sq.size() > 0 && sq[0].cyc == cyc);
            chk("sum_valid", sum_valid, exp_sv);
            if (exp_sv) begin
                chk("sum_tag", sum_tag, sq[0].tag);
                void'(sq.pop_front());
            end
            if (sum_valid === 1'b1) n_sv_seen++;
        end
    end

    task automatic xfer(input operand_t d, input bit last);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (in_ready !== 1'b1 && guard < 20) begin
            step();
            guard++;
        end
        if (guard >= 20) begin
            chk("ready_timeout", in_ready, 1);
        end else begin
            model_accept(d, last);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            in_valid = 1'b0;
            in_data  = operand_t'($urandom);
            in_last  = 1'($urandom);
            step();
        end
    endtask

    task automatic send_list(input operand_t v[$], input bit last_end, input int max_gap);
        for (int i = 0; i < v.size(); i++) begin
            xfer(v[i], last_end && (i == v.size() - 1));
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
    endtask

    task automatic random_frame(input int max_gap);
        operand_t v[$];
        int       len;
        bit       last;
        len = $urandom_range(1, N);
        for (int i = 0; i < len; i++) v.push_back(operand_t'($urandom));
        last = (len < N) ? 1'b1 : 1'($urandom);
        send_list(v, last, max_gap);
    endtask

    task automatic reset_dut(input int pre);
        repeat (pre) step();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        fq.delete();
        sq.delete();
        cur.delete();
        next_tag = '0;
        exp_ops  = '0;
        exp_ftag = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        operand_t v[$];
        int       seen;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        next_tag = '0;
        exp_ops  = '0;
        exp_ftag = '0;
        step();
        mon_en = 1'b1;
        step();
        rst = 1'b0;
        idle(2);

        // Full frame 1..8 back-to-back
        v.delete();
        for (int i = 1; i <= 8; i++) v.push_back(operand_t'(i));
        send_list(v, 1'b0, 0);
        step();
        chk("full_ops", operands, 64'h0807_0605_0403_0201);
        chk("full_tag", frame_tag, 0);
        idle(4);

        // Short frame, zero-padded
        v.delete();
        repeat (3) v.push_back(8'hFF);
        send_list(v, 1'b1, 0);
        step();
        chk("short_ops", operands, 64'h0000_0000_00FF_FFFF);
        chk("short_tag", frame_tag, 1);
        idle(4);

        // Maximum values
        v.delete();
        repeat (8) v.push_back(8'hFF);
        send_list(v, 1'b0, 0);
        step();
        chk("max_ops", operands, 64'hFFFF_FFFF_FFFF_FFFF);
        idle(4);

        // in_last on the eighth operand
        v.delete();
        for (int i = 1; i <= 8; i++) v.push_back(operand_t'(i));
        send_list(v, 1'b1, 0);
        step();
        chk("last8_ops", operands, 64'h0807_0605_0403_0201);
        chk("last8_tag", frame_tag, 3);
        idle(4);

        // 20 frames with random gaps, tags wrap
        reset_dut(1);
        seen = n_sv_seen;
        repeat (20) random_frame(2);
        idle(6);
        chk("sum_count", n_sv_seen - seen, 20);

        // Reset after 5 operands of a frame
        v.delete();
        for (int i = 0; i < 5; i++) v.push_back(operand_t'(8'h11 * (i + 1)));
        send_list(v, 1'b0, 0);
        reset_dut(0);
        v.delete();
        for (int i = 1; i <= 8; i++) v.push_back(operand_t'(i));
        send_list(v, 1'b0, 0);
        step();
        chk("post_rst_ops", operands, 64'h0807_0605_0403_0201);
        chk("post_rst_tag", frame_tag, 0);
        idle(4);

        // Reset the cycle after frame_valid: no sum_valid for it
        seen = n_sv_seen;
        v.delete();
        repeat (8) v.push_back(operand_t'($urandom));
        send_list(v, 1'b0, 0);
        reset_dut(1);
        idle(5);
        chk("flush_sum", n_sv_seen - seen, 0);

        // Reset during ISSUE: frame never issued
        seen = n_sv_seen;
        v.delete();
        repeat (8) v.push_back(operand_t'($urandom));
        send_list(v, 1'b0, 0);
        reset_dut(0);
        idle(5);
        chk("issue_rst_sum", n_sv_seen - seen, 0);

        // Random traffic
        repeat (30) random_frame(3);
        idle(6);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
